// File: rtl/kernel_cu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cu_sequencer_pkg
// Description : Shared kernel-control package: control-chain state enums and
//               compute-unit sequencer limits.
// Revision    : 1.0
// ============================================================================
package kernel_cu_sequencer_pkg;

    localparam int CU_SEQ_MAX_CUS = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP_WAIT = 3'd1,
        START      = 3'd2,
        BUSY       = 3'd3,
        DONE       = 3'd4,
        ERROR      = 3'd5
    } cu_sequencer_state;

endpackage
`default_nettype wire

// File: rtl/kernel_cu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cu_sequencer_if
// Description : Descriptor, setup, start and completion signals between the
//               kernel control block, the CU sequencer and the CU array.
// Revision    : 1.0
// ============================================================================
interface kernel_cu_sequencer_if #(
    parameter int NUM_CUS = 4
);
    logic               descriptor_valid;
    logic [NUM_CUS-1:0] cu_setup_req;
    logic [NUM_CUS-1:0] cu_setup_ack;
    logic [NUM_CUS-1:0] cu_start;
    logic [NUM_CUS-1:0] cu_done;
    logic               setup_done;
    logic               kernel_done;
    logic [NUM_CUS-1:0] cu_done_mask;
    logic               timeout_error;

    // Control block / CU array side
    modport master (
        output descriptor_valid,
        output cu_setup_ack,
        output cu_done,
        input  cu_setup_req,
        input  cu_start,
        input  setup_done,
        input  kernel_done,
        input  cu_done_mask,
        input  timeout_error
    );

    // Sequencer side
    modport slave (
        input  descriptor_valid,
        input  cu_setup_ack,
        input  cu_done,
        output cu_setup_req,
        output cu_start,
        output setup_done,
        output kernel_done,
        output cu_done_mask,
        output timeout_error
    );
endinterface
`default_nettype wire

// File: rtl/kernel_cu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kernel_cu_sequencer
// Description : Serial per-CU setup handshake, broadcast start and completion
//               collection for the compute units behind kernel control.
// Revision    : 1.0
// ============================================================================
module kernel_cu_sequencer
    import kernel_cu_sequencer_pkg::*;
#(
    parameter int NUM_CUS        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 ap_clk,
    input  logic                 areset,
    kernel_cu_sequencer_if.slave bus
);

    localparam int c_IDX_W = (NUM_CUS > 1) ? $clog2(NUM_CUS) : 1;
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_CUS - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX  = '1;
    localparam logic [NUM_CUS-1:0] c_ALL_CUS  = '1;

    cu_sequencer_state state_q, state_d;
    logic [c_IDX_W-1:0] idx_q, idx_d;
    logic [c_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CUS-1:0] mask_q, mask_d;
    logic [NUM_CUS-1:0] setup_req_q, setup_req_d;
    logic [NUM_CUS-1:0] start_q, start_d;
    logic               setup_done_q, setup_done_d;
    logic               kernel_done_q, kernel_done_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_CUS-1:0] w_ack_hit;
    logic               w_ack_sel;

    // Only the ack of the CU currently being configured is honoured
    for (genvar i = 0; i < NUM_CUS; i++) begin : g_ack_sel
        assign w_ack_hit[i] = bus.cu_setup_ack[i] && (idx_q == c_IDX_W'(i));
    end
    assign w_ack_sel = |w_ack_hit;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            tmo_cnt_q     <= '0;
            mask_q        <= '0;
            setup_req_q   <= '0;
            start_q       <= '0;
            setup_done_q  <= 1'b0;
            kernel_done_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mask_q        <= mask_d;
            setup_req_q   <= setup_req_d;
            start_q       <= start_d;
            setup_done_q  <= setup_done_d;
            kernel_done_q <= kernel_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_cnt_d = tmo_cnt_q;
        mask_d    = mask_q;

        unique case (state_q)
            IDLE: begin
                idx_d     = '0;
                tmo_cnt_d = '0;
                mask_d    = '0;
                if (bus.descriptor_valid) begin
                    state_d = SETUP_WAIT;
                end
            end
            SETUP_WAIT: begin
                if (!bus.descriptor_valid) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    tmo_cnt_d = '0;
                    mask_d    = '0;
                end else if (w_ack_sel) begin
                    tmo_cnt_d = '0;
                    if (idx_q == c_IDX_LAST) begin
                        state_d = START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    if (tmo_cnt_q != c_TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    // This cycle's increment is the one that reaches the limit
                    if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == c_TMO_LAST)) begin
                        state_d = ERROR;
                    end
                end
            end
            START: begin
                if (!bus.descriptor_valid) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    mask_d  = '0;
                end else begin
                    mask_d  = mask_q | bus.cu_done;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.descriptor_valid) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_q | bus.cu_done;
                    if (mask_d == c_ALL_CUS) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.descriptor_valid) begin
                    state_d = IDLE;
                    mask_d  = '0;
                end
            end
            ERROR: begin
                idx_d     = '0;
                tmo_cnt_d = '0;
                mask_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change with it
        for (int i = 0; i < NUM_CUS; i++) begin
            setup_req_d[i] = (state_d == SETUP_WAIT) && (idx_d == c_IDX_W'(i));
        end
        setup_done_d  = (state_d == START) || (state_d == BUSY);
        start_d       = setup_done_d ? c_ALL_CUS : '0;
        kernel_done_d = (state_d == DONE);
        timeout_err_d = timeout_err_q || (state_d == ERROR);
    end

    assign bus.cu_setup_req  = setup_req_q;
    assign bus.cu_start      = start_q;
    assign bus.setup_done    = setup_done_q;
    assign bus.kernel_done   = kernel_done_q;
    assign bus.cu_done_mask  = mask_q;
    assign bus.timeout_error = timeout_err_q;

endmodule
`default_nettype wire

// File: doc/kernel_cu_sequencer.md
# kernel_cu_sequencer

Sequences the compute units (CUs) behind the kernel control block. On a valid kernel descriptor it runs a serial per-CU setup handshake, then broadcasts start and collects per-CU completion. It reports aggregate setup-complete and kernel-done back to the control block's `setup`/`done` inputs. It sits between kernel control and the CU array.

## Interface
Parameters:
- `NUM_CUS`, 4: number of sequenced CUs; legal range 1..16.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for one setup ack; 0 disables the timeout.

Ports:
- `ap_clk`  in  1  kernel clock.
- `areset`  in  1  reset; asynchronous, active-high.
- `descriptor_valid`  in  1  kernel descriptor valid, level, from kernel control.
- `cu_setup_req`  out  NUM_CUS  setup request to CU i; at most one bit high.
- `cu_setup_ack`  in  NUM_CUS  setup acknowledge from CU i; level or pulse.
- `cu_start`  out  NUM_CUS  start level to all CUs.
- `cu_done`  in  NUM_CUS  completion pulse from CU i.
- `setup_done`  out  1  all CUs configured; drives control `setup`.
- `kernel_done`  out  1  all CUs finished; drives control `done`.
- `cu_done_mask`  out  NUM_CUS  per-CU completion status.
- `timeout_error`  out  1  sticky setup-timeout flag.

## Operation
- FSM states: IDLE, SETUP_WAIT, START, BUSY, DONE, ERROR.
- IDLE:
  - All outputs 0; index `idx` = 0; mask = 0; timeout counter = 0.
  - `descriptor_valid`=1 -> SETUP_WAIT.
- SETUP_WAIT:
  - `cu_setup_req[idx]` = 1; timeout counter increments each cycle.
  - On `cu_setup_ack[idx]`=1: counter clears.
    - If idx < NUM_CUS-1: idx++, stay in SETUP_WAIT.
    - Else -> START.
  - Ack bits for indices other than idx are ignored.
  - Counter reaches TIMEOUT_CYCLES with no ack (TIMEOUT_CYCLES≠0) -> ERROR.
- START: `setup_done`=1 and `cu_start` = all ones; both held through BUSY. Next state BUSY unconditionally.
- BUSY:
  - mask |= `cu_done`.
  - A repeated done pulse from an already-set bit is a no-op.
  - Mask becomes all ones -> DONE.
- DONE:
  - `kernel_done`=1, `setup_done`=0, `cu_start`=0; mask held.
  - `descriptor_valid`=0 -> IDLE, where mask clears.
- Abort: `descriptor_valid`=0 in SETUP_WAIT, START or BUSY -> IDLE. All requests and starts drop, idx and mask clear; `timeout_error` is unaffected.
- ERROR:
  - `timeout_error`=1; all other outputs 0.
  - Only `areset` exits; `descriptor_valid` is ignored.
- Simultaneous events:
  - Ack and timeout expiry in the same cycle: the ack wins.
  - Completing done pulse and `descriptor_valid` drop in the same cycle: abort wins, so no `kernel_done`.
- Widths:
  - idx is max(1, $clog2(NUM_CUS)) bits.
  - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.

## Timing
- All outputs are registered. Reset value of every output is 0, including `timeout_error`.
- `areset` asserted mid-operation forces IDLE and clears all outputs asynchronously. The first transition occurs on the first `ap_clk` edge after deassertion.
- Setup request timing:
  - `descriptor_valid` sampled high at edge t -> `cu_setup_req[0]` high from t+1.
  - Ack for idx sampled at edge t -> `cu_setup_req[idx]` low and `cu_setup_req[idx+1]` high from t+1. There is no gap cycle and no overlap.
- Minimum setup latency is NUM_CUS+1 cycles from descriptor to `setup_done`, with acks returned immediately.
- Last ack sampled at edge t -> `setup_done` and `cu_start` high from t+1 (START state).
- `cu_done[i]` sampled at edge t -> `cu_done_mask[i]` high from t+1. If that completes the mask, `kernel_done` is also high from t+1.
- Done pulses arriving during START are captured, because the mask updates in START as well as BUSY.

## Structure
- Add `cu_sequencer_state` enum (IDLE..ERROR) to the shared control package, next to the existing control-chain state enums.
- Add `CU_SEQ_MAX_CUS` = 16 to the same package.
- Single module; no sub-module required. The done-mask accumulator stays inline.

## Test plan
- NUM_CUS=4, acks returned 1 cycle after each req -> req one-hot walks 0001, 0010, 0100, 1000; `setup_done` rises 1 cycle after the ack from CU3.
- Done pulses in order CU2, CU0, CU0 again, CU3, CU1 -> mask goes 0100, 0101, 0101, 1101, 1111; `kernel_done` rises with mask 1111; dropping `descriptor_valid` returns to IDLE with mask 0000.
- TIMEOUT_CYCLES=8, CU1 never acks -> ERROR 8 cycles after `cu_setup_req[1]` rises; `timeout_error`=1 with all else 0; it persists with `descriptor_valid` toggling until `areset`.
- `descriptor_valid` dropped in BUSY with mask 0011 -> next cycle `cu_start`=0, mask 0000, no `kernel_done`; a new descriptor restarts setup at CU0.
- `areset` pulsed asynchronously while `cu_setup_req`=0100 -> all outputs 0 immediately, without waiting for a clock edge.
- NUM_CUS=1 -> single ack gives `setup_done`; a single done pulse gives `kernel_done`.
